sqrt_10bit_iter: RTL and testbench

SQRT_10BIT_ITER -- requirements
Module: sqrt_10bit_iter

---
 rtl/sqrt_pkg.sv | 13 +
 rtl/sqrt_step.sv | 28 ++
 rtl/sqrt_10bit_iter.sv | 101 ++++++++++
 tb/tb_sqrt_10bit_iter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared widths and FSM encoding for the iterative 10-bit integer square root.
package sqrt_pkg;
  localparam int IN_W   = 10;
  localparam int ROOT_W = IN_W / 2;
  localparam int REM_W  = ROOT_W + 1;
  localparam int ACC_W  = ROOT_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: shift in a radicand pair,
// trial-subtract (q<<2)|1, and produce the next partial root and remainder.
module sqrt_step
  import sqrt_pkg::*;
#(
  parameter int ROOT_W = sqrt_pkg::ROOT_W
) (
  input  logic [ROOT_W+1:0] r_in,
  input  logic [ROOT_W-1:0] q_in,
  input  logic [1:0]        pair,
  output logic [ROOT_W+1:0] r_out,
  output logic [ROOT_W-1:0] q_out
);
  localparam int ACC_W = ROOT_W + 2;

  logic [ACC_W-1:0] r_sh;
  logic [ACC_W-1:0] t;
  logic             ge;

  // Partial remainder never exceeds 2*q, so the top bits shifted out are zero.
  always_comb begin
    r_sh  = ACC_W'({r_in, pair});
    t     = {q_in, 2'b01};
    ge    = (r_sh >= t);
    r_out = ge ? (r_sh - t) : r_sh;
    q_out = {q_in[ROOT_W-2:0], ge};
  end
endmodule

// File: rtl/sqrt_10bit_iter.sv
// Iterative unsigned integer square root: one root bit per CALC cycle, MSB pair first.
// Handshake: start is sampled only in IDLE/DONE; done pulses one cycle with root/rem valid, which then hold until the next completion.
module sqrt_10bit_iter
  import sqrt_pkg::*;
#(
  parameter int IN_W   = sqrt_pkg::IN_W,
  parameter int ROOT_W = IN_W / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   x,
  output logic [ROOT_W-1:0] root,
  output logic [ROOT_W:0]   rem,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state
);
  localparam int REM_W = ROOT_W + 1;
  localparam int ACC_W = ROOT_W + 2;
  localparam int CNT_W = $clog2(ROOT_W + 1);

  state_t            state_q, state_d;
  logic [IN_W-1:0]   x_q, x_d;
  logic [ACC_W-1:0]  r_q, r_d, r_nxt;
  logic [ROOT_W-1:0] q_q, q_d, q_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [1:0]        pair;

  assign pair = 2'(x_q >> {cnt_q, 1'b0});

  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .pair  (pair),
    .r_out (r_nxt),
    .q_out (q_nxt)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          x_d     = x;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CNT_W'(ROOT_W - 1);
        end
      end
      CALC: begin
        r_d = r_nxt;
        q_d = q_nxt;
        if (cnt_q == '0) begin
          state_d = DONE;
          root_d  = q_nxt;
          rem_d   = r_nxt[REM_W-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  assign root      = root_q;
  assign rem       = rem_q;
  assign busy      = (state_q == CALC);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_sqrt_10bit_iter.sv
// Self-checking bench for sqrt_10bit_iter against a brute-force integer square-root model.
module tb_sqrt_10bit_iter;
  import sqrt_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x = '0;
  logic [4:0] root;
  logic [5:0] rem;
  logic       busy, done;
  state_t     dbg_state;

  int n_total = 0;
  int n_pass  = 0;

  sqrt_10bit_iter dut (
    .clk(clk), .rst(rst), .start(start), .x(x),
    .root(root), .rem(rem), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Largest r with r*r <= v, found by counting up.
  function automatic int isqrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
    n_total++; if (root !== 5'd0) $display("FAIL reset_root got %0d want 0", root); else n_pass++;
    n_total++; if (rem !== 6'd0)  $display("FAIL reset_rem got %0d want 0", rem); else n_pass++;
    n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d want IDLE", dbg_state); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from IDLE; optionally pulse reset so start lands on the first edge after release.
  task automatic run_one(input logic [9:0] xv, input bit pulse_rst);
    int busy_cnt, cyc, er, em, xi;
    bit got;
    xi = int'(xv);
    er = isqrt(xi);
    em = xi - er * er;
    @(negedge clk);
    if (pulse_rst) begin rst = 1'b1; #1; rst = 1'b0; end
    start = 1'b1; x = xv;
    @(negedge clk);
    start = 1'b0; x = 10'($urandom_range(0, 1023));
    busy_cnt = 0; got = 0; cyc = 0;
    while (!got && cyc < 20) begin
      n_total++; if (busy && done) $display("FAIL busy_done_excl x=%0d both high", xv); else n_pass++;
      if (busy) busy_cnt++;
      if (done) got = 1;
      else begin @(negedge clk); cyc++; end
    end
    n_total++; if (!got) $display("FAIL done_timeout x=%0d got none want done", xv); else n_pass++;
    n_total++; if (busy_cnt != 5) $display("FAIL busy_cycles x=%0d got %0d want 5", xv, busy_cnt); else n_pass++;
    n_total++; if (root !== 5'(er)) $display("FAIL root x=%0d got %0d want %0d", xv, root, er); else n_pass++;
    n_total++; if (rem !== 6'(em)) $display("FAIL rem x=%0d got %0d want %0d", xv, rem, em); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0) $display("FAIL done_pulse x=%0d got %0b want 0", xv, done); else n_pass++;
    n_total++; if (root !== 5'(er)) $display("FAIL root_hold x=%0d got %0d want %0d", xv, root, er); else n_pass++;
  endtask

  task automatic test_corners;
    run_one(10'd0, 0);
    run_one(10'd1023, 0);
    n_total++; if (root !== 5'd31 || rem !== 6'd62) $display("FAIL max_const got %0d/%0d want 31/62", root, rem); else n_pass++;
    run_one(10'd961, 0);
    run_one(10'd960, 0);
    n_total++; if (root !== 5'd30 || rem !== 6'd60) $display("FAIL x960_const got %0d/%0d want 30/60", root, rem); else n_pass++;
    run_one(10'd1, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) run_one(10'($urandom_range(0, 1023)), 0);
  endtask

  task automatic test_ignore_start;
    int n_done;
    @(negedge clk); start = 1'b1; x = 10'd500;
    @(negedge clk); start = 1'b0; x = 10'd17;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        n_done++;
        n_total++; if (root !== 5'd22 || rem !== 6'd16) $display("FAIL ignore_start got %0d/%0d want 22/16", root, rem); else n_pass++;
      end
      @(negedge clk);
    end
    n_total++; if (n_done != 1) $display("FAIL ignore_start_dones got %0d want 1", n_done); else n_pass++;
  endtask

  task automatic test_async_reset;
    int n_done;
    @(negedge clk); start = 1'b1; x = 10'd700;
    @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL arst_busy got %0b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL arst_done got %0b want 0", done); else n_pass++;
    n_total++; if (root !== 5'd0 || rem !== 6'd0) $display("FAIL arst_result got %0d/%0d want 0/0", root, rem); else n_pass++;
    n_total++; if (dbg_state !== IDLE) $display("FAIL arst_state got %0d want IDLE", dbg_state); else n_pass++;
    @(negedge clk); rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    n_total++; if (n_done != 0) $display("FAIL arst_no_done got %0d active cycles want 0", n_done); else n_pass++;
    run_one(10'd200, 0);
    run_one(10'd899, 1);
  endtask

  task automatic test_back_to_back;
    int cyc, last, n;
    @(negedge clk); start = 1'b1; x = 10'd144;
    @(negedge clk); x = 10'd143;
    cyc = 1; last = -1; n = 0;
    while (n < 2 && cyc < 30) begin
      if (done) begin
        if (n == 0) begin
          n_total++; if (root !== 5'd12 || rem !== 6'd0) $display("FAIL b2b_first got %0d/%0d want 12/0", root, rem); else n_pass++;
        end else begin
          n_total++; if (root !== 5'd11 || rem !== 6'd22) $display("FAIL b2b_second got %0d/%0d want 11/22", root, rem); else n_pass++;
          n_total++; if (cyc - last != 6) $display("FAIL b2b_period got %0d want 6", cyc - last); else n_pass++;
          start = 1'b0;
        end
        last = cyc; n++;
      end
      @(negedge clk); cyc++;
    end
    n_total++; if (n != 2) $display("FAIL b2b_timeout got %0d dones want 2", n); else n_pass++;
    n_total++; if (dbg_state !== IDLE) $display("FAIL b2b_idle got %0d want IDLE", dbg_state); else n_pass++;
  endtask

  task automatic test_sweep;
    int cyc, last, n, r, m;
    @(negedge clk); start = 1'b1; x = 10'd0;
    cyc = 0; last = -1; n = 0;
    while (n < 1024 && cyc < 1024 * 6 + 50) begin
      @(negedge clk); cyc++;
      if (done) begin
        r = int'(root); m = int'(rem);
        n_total++; if (r * r + m != n || m > 2 * r) $display("FAIL sweep x=%0d got %0d/%0d", n, r, m); else n_pass++;
        n_total++; if (r != isqrt(n)) $display("FAIL sweep_model x=%0d got %0d want %0d", n, r, isqrt(n)); else n_pass++;
        if (last >= 0) begin
          n_total++; if (cyc - last != 6) $display("FAIL sweep_period x=%0d got %0d want 6", n, cyc - last); else n_pass++;
        end
        last = cyc; n++;
        x = 10'(n);
        if (n == 1024) start = 1'b0;
      end
    end
    n_total++; if (n != 1024) $display("FAIL sweep_timeout got %0d results want 1024", n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_corners();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
